// File: rtl/and_reduce_pipe.sv
// Pipelined multi-channel AND/NAND reduction.
// Balanced pairwise tree, one register stage per level.
module and_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int NIN   = 4
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic                 EN,
    input  logic                 IV,
    input  logic [NIN*WIDTH-1:0] A,
    input  logic                 INV,
    output logic [WIDTH-1:0]     Y,
    output logic                 OV
);

    localparam int LAT = (NIN <= 2) ? 1 : $clog2(NIN);

    function automatic int level_cnt(input int lvl);
        int n;
        n = NIN;
        for (int i = 0; i < lvl; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    logic [LAT-1:0] vld_q;
    logic           mode_fin;

    // valid chain: bit l-1 belongs to tree level l
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            vld_q <= '0;
        end else if (EN) begin
            vld_q <= LAT'({vld_q, IV});
        end
    end

    // the final stage consumes the mode bit, so it needs no flop of its own
    if (LAT == 1) begin : g_mode1
        assign mode_fin = INV;
    end else begin : g_moden
        logic [LAT-2:0] mode_q;

        always_ff @(posedge CLK or negedge R) begin
            if (!R) begin
                mode_q <= '0;
            end else if (EN) begin
                mode_q <= (LAT-1)'({mode_q, INV});
            end
        end

        assign mode_fin = mode_q[LAT-2];
    end

    for (genvar l = 0; l <= LAT; l++) begin : g_lvl
        localparam int NC = level_cnt(l);
        logic [WIDTH-1:0] q [NC];

        if (l == 0) begin : g_in
            for (genvar j = 0; j < NC; j++) begin : g_ch
                assign q[j] = A[j*WIDTH +: WIDTH];
            end
        end else begin : g_st
            localparam int NP = level_cnt(l - 1);
            logic [WIDTH-1:0] d [NC];

            for (genvar j = 0; j < NC; j++) begin : g_pair
                logic [WIDTH-1:0] lo;
                logic [WIDTH-1:0] hi;

                assign lo = g_lvl[l-1].q[2*j];

                // odd trailing entry passes through
                if (2*j + 1 < NP) begin : g_two
                    assign hi = g_lvl[l-1].q[2*j+1];
                end else begin : g_one
                    assign hi = '1;
                end

                if (l == LAT) begin : g_last
                    assign d[j] = (lo & hi) ^ {WIDTH{mode_fin}};
                end else begin : g_mid
                    assign d[j] = lo & hi;
                end
            end

            always_ff @(posedge CLK or negedge R) begin
                if (!R) begin
                    for (int i = 0; i < NC; i++) begin
                        q[i] <= '0;
                    end
                end else if (EN) begin
                    for (int i = 0; i < NC; i++) begin
                        q[i] <= d[i];
                    end
                end
            end
        end
    end

    assign Y  = g_lvl[LAT].q[0];
    assign OV = vld_q[LAT-1];

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Scoreboard bench for and_reduce_pipe over several NIN/WIDTH
// configurations driven in lockstep from one shared stimulus.
module tb_and_reduce_pipe;

    localparam int NK = 7;
    localparam int NINS [NK] = '{4, 5, 1, 2, 3, 8, 16};
    localparam int WS   [NK] = '{8, 4, 1, 8, 8, 8, 8};

    typedef struct {
        logic [63:0] y;
        int          due;
    } ent_t;

    logic           CLK = 1'b0;
    logic           R   = 1'b0;
    logic           EN  = 1'b0;
    logic           IV  = 1'b0;
    logic           INV = 1'b0;
    logic [127:0]   abig = '0;
    logic [NK*64-1:0] y_flat;
    logic [NK-1:0]  ov_vec;

    ent_t        sbq [NK][$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          adv = 0;
    bit          loaded = 1'b0;
    bit          held_v [NK];
    logic [63:0] held_y [NK];

    for (genvar k = 0; k < NK; k++) begin : g_dut
        localparam int N = NINS[k];
        localparam int W = WS[k];
        logic [W-1:0] y;
        logic         ov;

        and_reduce_pipe #(.WIDTH(W), .NIN(N)) u_dut (
            .CLK(CLK),
            .R(R),
            .EN(EN),
            .IV(IV),
            .A(abig[N*W-1:0]),
            .INV(INV),
            .Y(y),
            .OV(ov)
        );

        assign y_flat[k*64 +: 64] = 64'(y);
        assign ov_vec[k] = ov;
    end

    always #5 CLK = ~CLK;

    function automatic int lat_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // flat reference: AND every channel, then optionally invert
    function automatic logic [63:0] model(input logic [127:0] a,
                                          input int n, input int w,
                                          input logic inv);
        logic [63:0] m;
        logic [63:0] r;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = m;
        for (int i = 0; i < n; i++) begin
            r = r & 64'(a >> (i * w)) & m;
        end
        if (inv) r = ~r & m;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] yk(input int k);
        return y_flat[k*64 +: 64];
    endfunction

    always @(posedge CLK) begin
        loaded = R && EN;
        if (loaded) adv++;
    end

    always @(negedge CLK) begin : mon
        ent_t e;
        if (R) begin
            for (int k = 0; k < NK; k++) begin
                if (loaded) begin
                    if (ov_vec[k]) begin
                        if (sbq[k].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL spurious_ov[%0d]: got OV=1, expected no result", k);
                        end else begin
                            e = sbq[k].pop_front();
                            chk($sformatf("latency[%0d]", k), 64'(adv), 64'(e.due));
                            chk($sformatf("result[%0d]", k), yk(k), e.y);
                        end
                        held_v[k] = 1'b1;
                        held_y[k] = yk(k);
                    end else begin
                        held_v[k] = 1'b0;
                        if (sbq[k].size() > 0 && sbq[k][0].due <= adv) begin
                            e = sbq[k].pop_front();
                            n_cmp++;
                            n_bad++;
                            $display("FAIL missing_ov[%0d]: got OV=0, expected Y=%0h", k, e.y);
                        end
                    end
                end else begin
                    chk($sformatf("stall_ov[%0d]", k), 64'(ov_vec[k]), 64'(held_v[k]));
                    if (held_v[k]) begin
                        chk($sformatf("stall_y[%0d]", k), yk(k), held_y[k]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #2;
    endtask

    // drive one valid transaction; instance hk uses hand value hy
    task automatic present(input logic [127:0] a, input logic inv,
                           input int hk, input logic [63:0] hy);
        ent_t e;
        abig = a;
        INV  = inv;
        IV   = 1'b1;
        EN   = 1'b1;
        for (int k = 0; k < NK; k++) begin
            e.y   = (k == hk) ? hy : model(a, NINS[k], WS[k], inv);
            e.due = adv + lat_of(NINS[k]);
            sbq[k].push_back(e);
        end
    endtask

    task automatic reset_sb();
        for (int k = 0; k < NK; k++) begin
            sbq[k].delete();
            held_v[k] = 1'b0;
        end
    endtask

    function automatic logic [127:0] rnd_ones();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i*32 +: 32] = $urandom | $urandom | $urandom;
        end
        return v;
    endfunction

    localparam logic [127:0] A0 = 128'hFFF03CFF;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        reset_sb();
        step();
        step();
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("rst_y[%0d]", k), yk(k), 64'h0);
            chk($sformatf("rst_ov[%0d]", k), 64'(ov_vec[k]), 64'h0);
        end
        R  = 1'b1;
        EN = 1'b1;
        step();
        step();

        // basic AND, latency 2
        present(A0, 1'b0, 0, 64'h30);
        step();
        IV = 1'b0;
        chk("basic_early_ov", 64'(ov_vec[0]), 64'h0);
        step();
        chk("basic_ov", 64'(ov_vec[0]), 64'h1);
        chk("basic_y", yk(0), 64'h30);
        step();
        chk("basic_ov_drop", 64'(ov_vec[0]), 64'h0);
        repeat (4) step();

        // alternating AND/NAND streaming
        for (int i = 0; i < 8; i++) begin
            present(A0, i[0], 0, i[0] ? 64'hCF : 64'h30);
            step();
        end
        IV = 1'b0;
        repeat (6) step();

        // stall mid-pipe with inputs changing underneath
        present(A0, 1'b0, 0, 64'h30);
        step();
        IV   = 1'b0;
        EN   = 1'b0;
        abig = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_no_ov", 64'(ov_vec[0]), 64'h0);
            abig = ~abig;
        end
        EN   = 1'b1;
        abig = 128'h12345678;
        step();
        chk("stall_ov", 64'(ov_vec[0]), 64'h1);
        chk("stall_y", yk(0), 64'h30);
        repeat (6) step();

        // odd channel count, NIN=5 WIDTH=4
        present(128'hF7EFF, 1'b0, 1, 64'h6);
        step();
        present(128'h07EFF, 1'b0, 1, 64'h0);
        step();
        IV = 1'b0;
        repeat (6) step();

        // degenerate NIN=1 WIDTH=1
        present(128'h1, 1'b1, 2, 64'h0);
        step();
        IV = 1'b0;
        chk("deg_ov", 64'(ov_vec[2]), 64'h1);
        chk("deg_y", yk(2), 64'h0);
        present(128'h1, 1'b0, 2, 64'h1);
        step();
        IV = 1'b0;
        repeat (6) step();

        // asynchronous reset with transactions in flight
        for (int i = 0; i < 3; i++) begin
            present(rnd_ones(), i[0], -1, 64'h0);
            step();
        end
        IV = 1'b0;
        #1;
        R = 1'b0;
        reset_sb();
        #1;
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("async_rst_y[%0d]", k), yk(k), 64'h0);
            chk($sformatf("async_rst_ov[%0d]", k), 64'(ov_vec[k]), 64'h0);
        end
        step();
        step();
        R = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_ov", 64'(ov_vec), 64'h0);
        end

        // random regression with EN gaps
        nv = 0;
        while (nv < 1000) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 4) != 0) begin
                    present(rnd_ones(), 1'($urandom_range(0, 1)), -1, 64'h0);
                    nv++;
                end else begin
                    IV   = 1'b0;
                    EN   = 1'b1;
                    abig = rnd_ones();
                end
            end else begin
                IV   = 1'b0;
                EN   = 1'b0;
                abig = rnd_ones();
            end
            step();
        end
        IV = 1'b0;
        EN = 1'b1;
        repeat (8) step();

        for (int k = 0; k < NK; k++) begin
            chk($sformatf("drained[%0d]", k), 64'(sbq[k].size()), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
